toggle_event_decoder: RTL

//   Receive side of the toggle-signalling link. The sender's T flip-flop flips tog_in once per event.

---
 rtl/toggle_event_decoder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/toggle_event_decoder.sv
// -----------------------------------------------------------------------------
// toggle_event_decoder
//
// Receive side of a toggle-signalling link. The sender's T flip-flop flips
// tog_in once per event. This block brings tog_in into the clk domain, turns
// each level change into one queued event and hands the events to local
// control logic over a valid/ready handshake. Pending events are held in a
// saturating counter. An event that arrives while the counter is full is
// dropped and sets a sticky overflow flag.
//
// Optional feature:
//   TOG_DEBOUNCE_EN  When defined, a level change must stay in place for
//                    DEBOUNCE_CYC cycles before it is accepted. Toggles shorter
//                    than that are ignored.
//
// Parameters:
//   SYNC_STAGES   synchroniser flops on tog_in (>= 2)
//   PEND_W        pending-counter width; capacity is 2**PEND_W-1 events
//   CNT_W         width of the free-running detected-event total
//   DEBOUNCE_CYC  stable cycles required before an edge is accepted (>= 1)
//
// Ports:
//   clk        in   clock; all logic runs on the rising edge
//   rst        in   synchronous, active-high reset (hold >= SYNC_STAGES cycles)
//   tog_in     in   asynchronous toggle level from the sender
//   evt_valid  out  at least one event is pending
//   evt_ready  in   consumer takes one event when evt_valid && evt_ready
//   pend_cnt   out  number of pending events
//   evt_total  out  detected edges, modulo 2**CNT_W, dropped ones included
//   overflow   out  sticky flag: an event was dropped because the queue was full
//   clr_ovf    in   clears overflow; a new drop in the same cycle wins
// -----------------------------------------------------------------------------
module toggle_event_decoder #(
   parameter int SYNC_STAGES  = 2,
   parameter int PEND_W       = 3,
   parameter int CNT_W        = 8,
   parameter int DEBOUNCE_CYC = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tog_in,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [PEND_W-1:0] pend_cnt,
   output logic [CNT_W-1:0]  evt_total,
   output logic              overflow,
   input  logic              clr_ovf
);

   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_out;
   logic                   ref_lvl;
   logic                   differ;
   logic                   detect;
   logic                   pop;
   logic                   full;
   logic [PEND_W-1:0]      pend_nxt;
   logic                   ovf_set;

   // NOTE: the synchroniser is deliberately left out of reset. It must keep
   // sampling during reset so that ref_lvl can track the settled level and no
   // false edge appears when reset is released.
   // NOTE: every clocked block uses non-blocking assignments so that all
   // registers update together from values sampled before the edge.
   always_ff @(posedge clk) begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tog_in};
   end

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign differ   = (sync_out != ref_lvl);

   // ref_lvl tracks the line during reset, so toggles seen during reset are
   // absorbed. After reset it moves only when an edge is accepted.
   always_ff @(posedge clk) begin
      if (rst || detect) begin
         ref_lvl <= sync_out;
      end
   end

`ifdef TOG_DEBOUNCE_EN
   localparam int              DB_W     = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [DB_W-1:0] DB_LIMIT = DB_W'(DEBOUNCE_CYC);

   logic [DB_W-1:0] db_cnt;

   // The counter measures how long the line has differed from ref_lvl. The
   // edge is accepted on the cycle the count reaches DEBOUNCE_CYC. That adds
   // exactly DEBOUNCE_CYC cycles of latency over the immediate detector.
   assign detect = differ && (db_cnt == DB_LIMIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         db_cnt <= '0;
      end else if (!differ || detect) begin
         db_cnt <= '0;
      end else begin
         db_cnt <= db_cnt + 1'b1;
      end
   end
`else
   assign detect = differ;
`endif

   // evt_valid depends only on registered state. There is no combinational
   // path from evt_ready to evt_valid.
   assign evt_valid = (pend_cnt != '0);
   assign pop       = evt_valid && evt_ready;
   assign full      = (pend_cnt == PEND_MAX);

   // NOTE: defaults are assigned first so that every path drives every
   // output and no latch is inferred.
   always_comb begin
      pend_nxt = pend_cnt;
      ovf_set  = 1'b0;
      unique case ({detect, pop})
         2'b10: begin
            if (full) begin
               ovf_set = 1'b1;
            end else begin
               pend_nxt = pend_cnt + 1'b1;
            end
         end
         2'b01:   pend_nxt = pend_cnt - 1'b1;
         default: pend_nxt = pend_cnt;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_cnt  <= '0;
         evt_total <= '0;
         overflow  <= 1'b0;
      end else begin
         pend_cnt <= pend_nxt;
         if (detect) begin
            evt_total <= evt_total + 1'b1;
         end
         if (ovf_set) begin
            overflow <= 1'b1;
         end else if (clr_ovf) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule
